// File: rtl/tcdm_amo_pkg.sv
// Shared AMO encoding and helpers for the TCDM atomic master and the bank-side AMO shim.
// Both ends import this package so the 4-bit opcode meaning cannot drift.
package tcdm_amo_pkg;

    typedef enum logic [3:0] {
        AmoNone = 4'h0,
        AmoSwap = 4'h1,
        AmoAdd  = 4'h2,
        AmoAnd  = 4'h3,
        AmoOr   = 4'h4,
        AmoXor  = 4'h5,
        AmoMax  = 4'h6,
        AmoMaxu = 4'h7,
        AmoMin  = 4'h8,
        AmoMinu = 4'h9,
        AmoCas  = 4'hA
    } amo_op_t;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Wait = 2'd2,
        Resp = 2'd3
    } amo_state_t;

    // CAS needs both bank halves (compare + swap), so it only works on the low word of a 64-bit bank.
    function automatic logic amo_illegal(input logic [3:0] amo,
                                         input logic [2:0] addr_lo,
                                         input logic       wide_bank);
        logic is_amo;
        logic is_cas;
        is_amo = (amo != AmoNone);
        is_cas = (amo == AmoCas);
        return (amo > AmoCas)
            || (is_amo && (addr_lo[1:0] != 2'b00))
            || (is_cas && (!wide_bank || addr_lo[2]));
    endfunction

endpackage

// File: rtl/amo_master.sv
// Requester-side adapter: turns a valid/ready atomic request into a single TCDM bank
// transaction and returns a buffered 32-bit response with an error flag.
module amo_master
    import tcdm_amo_pkg::*;
#(
    parameter  int unsigned AddrWidth    = 32,
    parameter  int unsigned DataWidth    = 64,
    localparam int unsigned ByteOff      = $clog2(DataWidth / 8),
    localparam int unsigned AddrMemWidth = AddrWidth - ByteOff
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [3:0]               req_amo_i,
    input  logic                     req_wen_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [31:0]              req_cmp_i,
    input  logic [3:0]               req_be_i,

    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [31:0]              resp_rdata_o,
    output logic                     resp_err_o,

    output logic                     tcdm_req_o,
    input  logic                     tcdm_gnt_i,
    output logic [AddrMemWidth-1:0]  tcdm_add_o,
    output logic [3:0]               tcdm_amo_o,
    output logic                     tcdm_wen_o,
    output logic [DataWidth-1:0]     tcdm_wdata_o,
    output logic [DataWidth/8-1:0]   tcdm_be_o,
    input  logic [DataWidth-1:0]     tcdm_rdata_i
);

    if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
        $fatal(1, "amo_master: DataWidth must be 32 or 64");
    end

    amo_state_t state_q, state_d;

    logic                    accept;
    logic                    illegal;
    logic                    is_amo;
    logic                    is_cas;
    logic [3:0]              be4;
    logic                    wen_in;
    logic [DataWidth-1:0]    wdata_st;
    logic [DataWidth/8-1:0]  be_st;
    logic [31:0]             rdata_sel;

    logic [AddrMemWidth-1:0] add_q;
    logic [3:0]              amo_q;
    logic                    wen_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth/8-1:0]  be_q;
    logic                    hi_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    assign is_amo  = (req_amo_i != AmoNone);
    assign is_cas  = (req_amo_i == AmoCas);
    assign illegal = amo_illegal(req_amo_i, req_addr_i[2:0], DataWidth == 64);
    assign accept  = (state_q == Idle) && req_valid_i;

    // AMOs always operate on the full word; the shim does its own write-back, so no bus store.
    assign be4    = is_amo ? 4'hF : req_be_i;
    assign wen_in = is_amo ? 1'b0 : req_wen_i;

    if (DataWidth == 64) begin : g_wide
        always_comb begin
            if (is_cas) begin
                wdata_st = {req_wdata_i, req_cmp_i};
                be_st    = 8'h0F;
            end else begin
                wdata_st = {2{req_wdata_i}};
                be_st    = req_addr_i[2] ? {be4, 4'h0} : {4'h0, be4};
            end
        end
        assign rdata_sel = hi_q ? tcdm_rdata_i[63:32] : tcdm_rdata_i[31:0];
    end else begin : g_narrow
        assign wdata_st  = req_wdata_i;
        assign be_st     = be4;
        assign rdata_sel = tcdm_rdata_i;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        tcdm_req_o   = 1'b0;
        unique case (state_q)
            Idle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = illegal ? Resp : Req;
                end
            end
            Req: begin
                tcdm_req_o = 1'b1;
                if (tcdm_gnt_i) begin
                    state_d = Wait;
                end
            end
            Wait: begin
                state_d = Resp;
            end
            Resp: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: datapath registers are reset as well because they drive the bus outputs directly.
            state_q <= Idle;
            add_q   <= '0;
            amo_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            hi_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state_q <= state_d;
            if (accept) begin
                add_q   <= req_addr_i[AddrWidth-1:ByteOff];
                amo_q   <= req_amo_i;
                wen_q   <= wen_in;
                wdata_q <= wdata_st;
                be_q    <= be_st;
                hi_q    <= req_addr_i[2];
                rdata_q <= '0;
                err_q   <= illegal;
            end
            // Bank data is only valid the cycle after grant; stores report zero.
            if (state_q == Wait) begin
                rdata_q <= wen_q ? 32'h0 : rdata_sel;
            end
        end
    end

    assign tcdm_add_o   = add_q;
    assign tcdm_amo_o   = amo_q;
    assign tcdm_wen_o   = wen_q;
    assign tcdm_wdata_o = wdata_q;
    assign tcdm_be_o    = be_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_amo_master.sv
// Directed bench for amo_master (64-bit bank): scoreboard queues fed at request acceptance,
// a bank model checking the TCDM side, and a monitor checking responses.
module tb_amo_master;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int AMW = 29;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i = '0;
    logic [3:0]      req_amo_i = '0;
    logic            req_wen_i = 1'b0;
    logic [31:0]     req_wdata_i = '0;
    logic [31:0]     req_cmp_i = '0;
    logic [3:0]      req_be_i = '0;
    logic            resp_valid_o;
    logic            resp_ready_i = 1'b1;
    logic [31:0]     resp_rdata_o;
    logic            resp_err_o;
    logic            tcdm_req_o;
    logic            tcdm_gnt_i = 1'b0;
    logic [AMW-1:0]  tcdm_add_o;
    logic [3:0]      tcdm_amo_o;
    logic            tcdm_wen_o;
    logic [DW-1:0]   tcdm_wdata_o;
    logic [DW/8-1:0] tcdm_be_o;
    logic [DW-1:0]   tcdm_rdata_i = 64'hBAD0BAD0_BAD0BAD0;

    amo_master #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_amo_i    (req_amo_i),
        .req_wen_i    (req_wen_i),
        .req_wdata_i  (req_wdata_i),
        .req_cmp_i    (req_cmp_i),
        .req_be_i     (req_be_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .tcdm_req_o   (tcdm_req_o),
        .tcdm_gnt_i   (tcdm_gnt_i),
        .tcdm_add_o   (tcdm_add_o),
        .tcdm_amo_o   (tcdm_amo_o),
        .tcdm_wen_o   (tcdm_wen_o),
        .tcdm_wdata_o (tcdm_wdata_o),
        .tcdm_be_o    (tcdm_be_o),
        .tcdm_rdata_i (tcdm_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  amo;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] cmp;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [AMW-1:0]  add;
        logic [3:0]      amo;
        logic            wen;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] be;
        int              dly;
        logic [DW-1:0]   rdata;
    } tcdm_t;

    exp_t  exp_q[$];
    tcdm_t tq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    stall  = 0;
    logic  in_resp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk_r(logic [31:0] addr, logic [3:0] amo, logic wen,
                                  logic [31:0] wdata, logic [31:0] cmp, logic [3:0] be);
        req_t r;
        r.addr = addr; r.amo = amo; r.wen = wen; r.wdata = wdata; r.cmp = cmp; r.be = be;
        return r;
    endfunction

    function automatic exp_t mk_e(logic [31:0] rdata, logic err, int lat);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    function automatic tcdm_t mk_t(logic [AMW-1:0] add, logic [3:0] amo, logic wen,
                                   logic [DW-1:0] wdata, logic [DW/8-1:0] be, int dly,
                                   logic [DW-1:0] rdata);
        tcdm_t t;
        t.add = add; t.amo = amo; t.wen = wen; t.wdata = wdata; t.be = be;
        t.dly = dly; t.rdata = rdata;
        return t;
    endfunction

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Response back-pressure: hold ready low for 'stall' cycles of a presented response.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (resp_valid_o && stall > 0) begin
            resp_ready_i = 1'b0;
            stall--;
        end else begin
            resp_ready_i = 1'b1;
        end
    end

    // Bank model: checks the request fields, holds grant off for the programmed delay.
    initial begin
        int            held;
        tcdm_t         ent;
        logic [106:0]  snap;
        held = 0;
        snap = '0;
        forever begin
            @(negedge clk_i);
            if (tcdm_req_o) begin
                if (tq.size() == 0) begin
                    check("spurious_tcdm_req", tcdm_req_o, 1'b0);
                    tcdm_gnt_i = 1'b1;
                    @(posedge clk_i);
                    #1;
                    tcdm_gnt_i = 1'b0;
                end else begin
                    if (held == 0) begin
                        check("tcdm_add",   tcdm_add_o,   tq[0].add);
                        check("tcdm_amo",   tcdm_amo_o,   tq[0].amo);
                        check("tcdm_wen",   tcdm_wen_o,   tq[0].wen);
                        check("tcdm_wdata", tcdm_wdata_o, tq[0].wdata);
                        check("tcdm_be",    tcdm_be_o,    tq[0].be);
                        snap = {tcdm_add_o, tcdm_amo_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o, 1'b0};
                    end else begin
                        check("tcdm_hold",
                              {tcdm_add_o, tcdm_amo_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o, req_ready_o},
                              snap);
                    end
                    if (held == tq[0].dly) begin
                        tcdm_gnt_i = 1'b1;
                        ent = tq.pop_front();
                        @(posedge clk_i);
                        #1;
                        tcdm_gnt_i   = 1'b0;
                        tcdm_rdata_i = ent.rdata;
                        @(posedge clk_i);
                        #1;
                        tcdm_rdata_i = 64'hBAD0BAD0_BAD0BAD0;
                        held = 0;
                    end else begin
                        held++;
                    end
                end
            end else begin
                held = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on the first cycle of each response.
    initial begin
        exp_t        e;
        logic [32:0] cur;
        cur = '0;
        forever begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", resp_valid_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata",   resp_rdata_o, e.rdata);
                        check("resp_err",     resp_err_o,   e.err);
                        check("resp_latency", cyc - e.acc,  e.lat);
                        cur = {resp_rdata_o, resp_err_o};
                    end
                end else begin
                    check("resp_hold", {resp_rdata_o, resp_err_o}, cur);
                end
                if (resp_ready_i) in_resp = 1'b0;
            end
        end
    end

    task automatic issue(input req_t r, input exp_t e, input logic has_t, input tcdm_t t,
                         output int acc);
        req_addr_i  = r.addr;
        req_amo_i   = r.amo;
        req_wen_i   = r.wen;
        req_wdata_i = r.wdata;
        req_cmp_i   = r.cmp;
        req_be_i    = r.be;
        req_valid_i = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                acc   = cyc;
                e.acc = cyc;
                exp_q.push_back(e);
                if (has_t) tq.push_back(t);
                break;
            end
        end
        if (acc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready_o stayed 0 for 100 cycles at addr %0h", r.addr);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() == 0 && tq.size() == 0 && !in_resp) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: %0d responses still pending after 200 cycles", exp_q.size());
            exp_q.delete();
            tq.delete();
            in_resp = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tcdm_req"},   tcdm_req_o,   1'b0);
        check({tag, "_resp_valid"}, resp_valid_o, 1'b0);
        check({tag, "_req_ready"},  req_ready_o,  1'b1);
    endtask

    tcdm_t none_t;
    int    acc_a, acc_b, acc_x;

    initial begin
        none_t = mk_t('0, 4'h0, 1'b0, '0, '0, 0, '0);

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("rst");
        check("rst_rdata",   resp_rdata_o, 32'h0);
        check("rst_err",     resp_err_o,   1'b0);
        check("rst_tcdm_bus", {tcdm_add_o, tcdm_amo_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o}, '0);
        @(posedge clk_i);
        #1;

        // AMOAdd 0x104, old upper word 7, immediate grant.
        issue(mk_r(32'h104, 4'h2, 1'b0, 32'h5, 32'h0, 4'h0), mk_e(32'h7, 1'b0, 3), 1'b1,
              mk_t(29'h20, 4'h2, 1'b0, 64'h00000005_00000005, 8'hF0, 0, 64'h00000007_DEADBEEF),
              acc_x);
        wait_idle();

        // CAS low word: {swap, cmp}, old value from the low half.
        issue(mk_r(32'h100, 4'hA, 1'b0, 32'h22, 32'h11, 4'h0), mk_e(32'h11, 1'b0, 3), 1'b1,
              mk_t(29'h20, 4'hA, 1'b0, 64'h00000022_00000011, 8'h0F, 0, 64'hAAAAAAAA_00000011),
              acc_x);
        wait_idle();

        // CAS on upper word is rejected without a bus transaction.
        issue(mk_r(32'h104, 4'hA, 1'b0, 32'h22, 32'h11, 4'h0), mk_e(32'h0, 1'b1, 1), 1'b0,
              none_t, acc_x);
        wait_idle();

        // Plain load with grant withheld 5 cycles.
        issue(mk_r(32'h108, 4'h0, 1'b0, 32'hCAFEF00D, 32'h0, 4'hF), mk_e(32'h9ABCDEF0, 1'b0, 8),
              1'b1, mk_t(29'h21, 4'h0, 1'b0, 64'hCAFEF00D_CAFEF00D, 8'h0F, 5, 64'h12345678_9ABCDEF0),
              acc_x);
        wait_idle();

        // Response stalled 4 cycles; a second request waits until after the handshake.
        stall = 4;
        issue(mk_r(32'h10C, 4'h0, 1'b0, 32'h0, 32'h0, 4'hF), mk_e(32'h12345678, 1'b0, 3), 1'b1,
              mk_t(29'h21, 4'h0, 1'b0, 64'h0, 8'hF0, 0, 64'h12345678_9ABCDEF0), acc_a);
        issue(mk_r(32'h110, 4'h5, 1'b1, 32'hFF, 32'h0, 4'h0), mk_e(32'h0000BEEF, 1'b0, 3), 1'b1,
              mk_t(29'h22, 4'h5, 1'b0, 64'h000000FF_000000FF, 8'h0F, 0, 64'h55555555_0000BEEF),
              acc_b);
        check("accept_after_hs", acc_b - acc_a, 8);
        wait_idle();

        // Misaligned AMOSwap and out-of-range opcode are errors.
        issue(mk_r(32'h102, 4'h1, 1'b0, 32'h1, 32'h0, 4'hF), mk_e(32'h0, 1'b1, 1), 1'b0,
              none_t, acc_x);
        wait_idle();
        issue(mk_r(32'h100, 4'hB, 1'b0, 32'h1, 32'h0, 4'hF), mk_e(32'h0, 1'b1, 1), 1'b0,
              none_t, acc_x);
        wait_idle();

        // Plain partial store: be 0x03, wen 1, response data 0.
        issue(mk_r(32'h100, 4'h0, 1'b1, 32'h0000A5A5, 32'h0, 4'h3), mk_e(32'h0, 1'b0, 3), 1'b1,
              mk_t(29'h20, 4'h0, 1'b1, 64'h0000A5A5_0000A5A5, 8'h03, 0, 64'hFFFFFFFF_FFFFFFFF),
              acc_x);
        wait_idle();

        // AMOMax forces full byte enables and wen 0 regardless of request fields.
        issue(mk_r(32'h108, 4'h6, 1'b1, 32'h80000000, 32'h0, 4'h0), mk_e(32'h00000042, 1'b0, 3),
              1'b1, mk_t(29'h21, 4'h6, 1'b0, 64'h80000000_80000000, 8'h0F, 0, 64'h0_00000042),
              acc_x);
        wait_idle();

        // Reset while holding a request.
        issue(mk_r(32'h118, 4'h2, 1'b0, 32'h3, 32'h0, 4'h0), mk_e(32'h0, 1'b0, 3), 1'b1,
              mk_t(29'h23, 4'h2, 1'b0, 64'h00000003_00000003, 8'h0F, 20, 64'h0), acc_x);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("rst_in_req");
        check("rst_in_req_add", tcdm_add_o, '0);
        exp_q.delete();
        tq.delete();
        @(posedge clk_i);
        #1;

        // Reset while a response is being presented.
        stall = 10;
        issue(mk_r(32'h120, 4'h2, 1'b0, 32'h1, 32'h0, 4'h0), mk_e(32'h00000099, 1'b0, 3), 1'b1,
              mk_t(29'h24, 4'h2, 1'b0, 64'h00000001_00000001, 8'h0F, 0, 64'h0_00000099), acc_x);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("rst_in_resp");
        check("rst_in_resp_rdata", resp_rdata_o, 32'h0);
        in_resp = 1'b0;
        stall   = 0;
        exp_q.delete();
        tq.delete();
        @(posedge clk_i);
        #1;

        // Recovery after reset.
        issue(mk_r(32'h104, 4'h2, 1'b0, 32'h5, 32'h0, 4'h0), mk_e(32'h0000000A, 1'b0, 3), 1'b1,
              mk_t(29'h20, 4'h2, 1'b0, 64'h00000005_00000005, 8'hF0, 0, 64'h0000000A_00000000),
              acc_x);
        wait_idle();

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
